// File: rtl/mem_arbiter.sv
// mem_arbiter: one memory bus shared by instruction fetch (I) and load/store (D), one transaction
// in flight, D priority with a starvation guard. Define ARB_TIMEOUT_EN to enable the bus wait timeout.
module mem_arbiter #(
   parameter int unsigned ADDR_WIDTH     = 64,
   parameter int unsigned DATA_WIDTH     = 64,
   parameter int unsigned STARVE_LIMIT   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_req_valid,
   output logic                    i_req_ready,
   input  logic [ADDR_WIDTH-1:0]   i_req_addr,
   output logic                    i_rsp_valid,
   output logic [DATA_WIDTH-1:0]   i_rsp_data,
   input  logic                    d_req_valid,
   output logic                    d_req_ready,
   input  logic [ADDR_WIDTH-1:0]   d_req_addr,
   input  logic                    d_req_wen,
   input  logic [DATA_WIDTH-1:0]   d_req_wdata,
   input  logic [DATA_WIDTH/8-1:0] d_req_wmask,
   output logic                    d_rsp_valid,
   output logic [DATA_WIDTH-1:0]   d_rsp_data,
   output logic                    bus_req_valid,
   input  logic                    bus_req_ready,
   output logic [ADDR_WIDTH-1:0]   bus_req_addr,
   output logic                    bus_req_wen,
   output logic [DATA_WIDTH-1:0]   bus_req_wdata,
   output logic [DATA_WIDTH/8-1:0] bus_req_wmask,
   input  logic                    bus_rsp_valid,
   input  logic [DATA_WIDTH-1:0]   bus_rsp_data,
   output logic                    busy,
   output logic                    rsp_err
);

   localparam int unsigned MASK_WIDTH   = DATA_WIDTH / 8;
   localparam int unsigned STREAK_WIDTH = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;
   typedef enum logic {OWN_I, OWN_D} owner_t;

   state_t                  r_state;
   state_t                  w_state_next;
   owner_t                  r_owner;
   logic [STREAK_WIDTH-1:0] r_streak;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic                    r_wen;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [MASK_WIDTH-1:0]   r_wmask;

   logic w_arb_en;
   logic w_starved;
   logic w_grant_i;
   logic w_grant_d;
   logic w_done;
   logic w_timeout;
   logic w_rsp_fire;

   if (STARVE_LIMIT == 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
      $error("mem_arbiter: STARVE_LIMIT and TIMEOUT_CYCLES must be non-zero");
   end

   // Handshake outputs are held low while rst is asserted, even in the reset cycle itself.
   assign w_arb_en   = (r_state == ST_IDLE) && !rst;
   assign w_starved  = (r_streak == STREAK_WIDTH'(STARVE_LIMIT));
   assign w_grant_d  = w_arb_en && d_req_valid && !(i_req_valid && w_starved);
   assign w_grant_i  = w_arb_en && i_req_valid && !w_grant_d;
   assign w_done     = (r_state == ST_RESP) && bus_rsp_valid && !rst;
   assign w_rsp_fire = w_done || w_timeout;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned WAIT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

   logic [WAIT_WIDTH-1:0] r_wait;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait <= '0;
      end else if (w_grant_i || w_grant_d) begin
         r_wait <= '0;
      end else if (r_state != ST_IDLE && r_wait != WAIT_WIDTH'(TIMEOUT_CYCLES)) begin
         r_wait <= r_wait + 1'b1;
      end
   end

   // A real response arriving on the timeout cycle wins over the error.
   assign w_timeout = (r_state != ST_IDLE) && !rst && !w_done &&
                      (r_wait == WAIT_WIDTH'(TIMEOUT_CYCLES));
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_i || w_grant_d) begin
               w_state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            if (w_timeout) begin
               w_state_next = ST_IDLE;
            end else if (bus_req_ready) begin
               w_state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            if (w_rsp_fire) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      i_req_ready   = 1'b0;
      d_req_ready   = 1'b0;
      bus_req_valid = 1'b0;
      i_rsp_valid   = 1'b0;
      d_rsp_valid   = 1'b0;
      if (!rst) begin
         case (r_state)
            ST_IDLE: begin
               i_req_ready = w_grant_i;
               d_req_ready = w_grant_d;
            end
            ST_REQ: begin
               bus_req_valid = 1'b1;
               i_rsp_valid   = w_timeout && (r_owner == OWN_I);
               d_rsp_valid   = w_timeout && (r_owner == OWN_D);
            end
            ST_RESP: begin
               i_rsp_valid = w_rsp_fire && (r_owner == OWN_I);
               d_rsp_valid = w_rsp_fire && (r_owner == OWN_D);
            end
            default: ;
         endcase
      end
   end

   assign i_rsp_data    = w_timeout ? '0 : bus_rsp_data;
   assign d_rsp_data    = w_timeout ? '0 : bus_rsp_data;
   assign rsp_err       = w_timeout;
   assign busy          = (r_state != ST_IDLE);
   assign bus_req_addr  = r_addr;
   assign bus_req_wen   = r_wen;
   assign bus_req_wdata = r_wdata;
   assign bus_req_wmask = r_wmask;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner  <= OWN_I;
         r_streak <= '0;
         r_addr   <= '0;
         r_wen    <= 1'b0;
         r_wdata  <= '0;
         r_wmask  <= '0;
      end else if (w_grant_d) begin
         r_owner <= OWN_D;
         r_addr  <= d_req_addr;
         r_wen   <= d_req_wen;
         r_wdata <= d_req_wdata;
         r_wmask <= d_req_wmask;
         if (i_req_valid && !w_starved) begin
            r_streak <= r_streak + 1'b1;
         end
      end else if (w_grant_i) begin
         r_owner  <= OWN_I;
         r_addr   <= i_req_addr;
         r_wen    <= 1'b0;
         r_wdata  <= '0;
         r_wmask  <= '0;
         r_streak <= '0;
      end
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one memory bus between the instruction-fetch port (I) and the MEM-stage load/store port (D) of the 5-stage core.
- Handles one outstanding transaction at a time, using valid/ready request and valid response handshakes.
- D has fixed priority over I; a starvation guard forces an I grant after a run of D grants.
- Sits between IF/MEM stages and the unified memory model, replacing the separate rom/memory accesses.

Parameters:
- ADDR_WIDTH, 64, address width on all ports.
- DATA_WIDTH, 64, read/write data width; wmask width is DATA_WIDTH/8.
- STARVE_LIMIT, 4, consecutive D grants with I pending before I is forced.
- TIMEOUT_CYCLES, 255, bus wait limit; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req_valid  in  1  fetch request
- i_req_ready  out  1  fetch request accepted
- i_req_addr  in  ADDR_WIDTH  fetch address
- i_rsp_valid  out  1  fetch response
- i_rsp_data  out  DATA_WIDTH  fetch data
- d_req_valid  in  1  load/store request
- d_req_ready  out  1  load/store request accepted
- d_req_addr  in  ADDR_WIDTH  data address
- d_req_wen  in  1  1 = store
- d_req_wdata  in  DATA_WIDTH  store data
- d_req_wmask  in  DATA_WIDTH/8  byte enables
- d_rsp_valid  out  1  load data / store ack
- d_rsp_data  out  DATA_WIDTH  load data
- bus_req_valid  out  1  bus request
- bus_req_ready  in  1  bus accepts request
- bus_req_addr  out  ADDR_WIDTH
- bus_req_wen  out  1
- bus_req_wdata  out  DATA_WIDTH
- bus_req_wmask  out  DATA_WIDTH/8
- bus_rsp_valid  in  1  bus response
- bus_rsp_data  in  DATA_WIDTH
- busy  out  1  state != IDLE
- rsp_err  out  1  timeout pulse (ARB_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset: state=IDLE, owner=I, streak=0. All valid/ready outputs and busy are 0. Bus payload registers are 0.
- States: IDLE, REQ, RESP.
- IDLE, arbitration is combinational on the current request valids:
  - only D valid -> D wins;
  - only I valid -> I wins;
  - both valid -> D wins unless streak==STARVE_LIMIT, in which case I wins.
- Winner's x_req_ready=1 in the same cycle; the loser's ready stays 0. ready is never 1 outside IDLE.
- On accept: latch addr/wen/wdata/wmask and owner, then go to REQ.
  - I requests latch wen=0 and wmask=0.
- Streak update on each grant:
  - D grant while i_req_valid=1 -> streak+1, saturating at STARVE_LIMIT;
  - D grant with I idle -> streak unchanged;
  - I grant -> streak=0.
- REQ: bus_req_valid=1 with the latched payload, held stable until bus_req_ready. On bus_req_ready go to RESP.
- RESP: wait for bus_rsp_valid.
  - Same cycle: owner's x_rsp_valid=1 and x_rsp_data=bus_rsp_data (combinational pass-through, exactly one cycle); go to IDLE.
  - Stores also receive a rsp_valid ack; the data value is don't-care.
- Non-owner rsp_valid is always 0.
- bus_rsp_valid while in IDLE or REQ is ignored.
- Minimum latency: accept at cycle N, bus_req_valid at N+1, rsp at N+2 (if ready at N+1 and rsp at N+2).
  - The next grant is possible at N+3 (the IDLE cycle).
- Requester valid dropping after accept has no effect; the transaction completes.
- Reset in REQ/RESP: abort, go to IDLE next cycle, no rsp delivered. A later stray bus_rsp_valid is ignored.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined, a wait counter clears on entry to REQ and increments each cycle in REQ/RESP.
  - If it reaches TIMEOUT_CYCLES before completion: rsp_err=1 for one cycle, owner's x_rsp_valid=1 with data 0, state -> IDLE.
  - A late bus_rsp_valid is then ignored.
- When undefined: no counter, rsp_err tied 0, and the arbiter waits indefinitely.

Test Plan:
- I only, addr 0x80000000; bus ready immediate, rsp data 0x00000013 one cycle later -> i_rsp_valid at cycle N+2 with 0x13; d_rsp_valid stays 0.
- I and D valid together, D store addr 0x80001000, wdata 0xDEADBEEF, mask 0x0F -> D granted first with bus_req_wen=1 and mask 0x0F; I granted in the following IDLE cycle.
- D valid continuously with I pending, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D; streak returns to 0 after the I grant.
- bus_req_ready held low 5 cycles -> bus_req_valid and payload stable for all 6 cycles; no second grant; busy=1 throughout.
- rst asserted in RESP, then bus_rsp_valid arrives -> no rsp_valid on either port; outputs at reset values; next I request served normally.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, bus never responds -> rsp_err and d_rsp_valid pulse once at cycle 8 after entering REQ; state IDLE.
